mux_pipe: RTL
=============

MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 Parameter NUM_CH, default 32, number of input channels (2..64).
REQ-002 Parameter DATA_W, default 2, width of each channel's data (1..32).
REQ-003 Derived SEL_W = ceil(log2(NUM_CH)), minimum 1; it is not user-overridable.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_data  in  NUM_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-008 in_valid  in  NUM_CH  per-channel valid.
REQ-009 in_ready  out  NUM_CH  per-channel ready; one-hot or zero.
REQ-010 sel  in  SEL_W  channel select (fixed mode).
REQ-011 rr_mode  in  1  1 = round-robin arbitration, 0 = fixed select; effective only when MUX_RR_EN is defined.
REQ-012 out_data  out  DATA_W  registered selected data.
REQ-013 out_ch  out  SEL_W  channel index of out_data.
REQ-014 out_valid  out  1  out_data holds a word.
REQ-015 out_ready  in  1  downstream accept.
REQ-016 sel_err  out  1  one-cycle pulse when sel >= NUM_CH.

Function
REQ-017 Output stage is a single-entry register; it "can load" when out_valid=0 or out_ready=1 in the same cycle.
REQ-018 Fixed mode: grant channel g=sel when sel<NUM_CH, in_valid[sel]=1 and the stage can load.
REQ-019 in_ready[g]=1 only in the granted cycle; all other in_ready bits 0; in_ready is combinational from in_valid, sel, out_valid, out_ready and arbiter state.
REQ-020 A transfer on channel g loads out_data=in_data[g], out_ch=g, out_valid=1 at the next rising edge (latency 1 cycle).
REQ-021 Stall: while out_valid=1 and out_ready=0, out_data and out_ch hold stable and no in_ready is asserted.
REQ-022 Simultaneous drain and load: when out_valid=1, out_ready=1 and a grant exists, the new word replaces the old in the same cycle (full throughput, 1 word/cycle).
REQ-023 Drain with no grant: out_valid falls to 0 at the next edge.
REQ-024 sel >= NUM_CH (possible when NUM_CH is not a power of 2): no grant, out_valid follows REQ-023, sel_err=1 registered for every such cycle.
REQ-025 sel and rr_mode changes take effect in the same cycle; a word already held in the output register is unaffected.
REQ-026 Round-robin: grant the first channel with in_valid=1 searching upward from last_grant+1, wrapping from NUM_CH-1 to 0; last_grant updates only on a completed transfer.
REQ-027 Round-robin: sel is ignored and sel_err is held at 0.

Reset
REQ-028 While rst=1: out_valid=0, out_data=0, out_ch=0, sel_err=0, last_grant=NUM_CH-1 (so channel 0 has first priority), in_ready=0.
REQ-029 Reset asserted mid-transfer discards the held word; no transfer completes in the cycle rst is high.
REQ-030 First grant is possible in the first clock edge after rst deasserts.

Configuration
REQ-031 Macro MUX_RR_EN defined: round-robin logic and last_grant register are present; rr_mode selects the mode.
REQ-032 MUX_RR_EN undefined: no arbiter logic; rr_mode is ignored and the block always operates in fixed mode.

Verification
REQ-033 NUM_CH=32, DATA_W=2, fixed mode, sweep sel 0..31 with in_data[i]=i%4, all valid, out_ready=1 -> after 1 cycle out_data=sel%4 and out_ch=sel for every value, with no alias between channels 12 and 13.
REQ-034 sel=5, in_valid[5]=1, out_ready=0 for 3 cycles -> out_valid=1, out_data stable, in_ready=0 for those cycles; out_ready=1 -> next word loads in the same cycle.
REQ-035 NUM_CH=24, sel=27 -> sel_err=1 the next cycle, in_ready=0, out_valid=0.
REQ-036 MUX_RR_EN defined, rr_mode=1, channels 3, 7 and 30 valid continuously, out_ready=1 -> grant order 3, 7, 30, 3, 7, ...
REQ-037 Assert rst while out_valid=1 and out_ready=0 -> out_valid=0 immediately, held word lost; after release, first RR grant goes to the lowest valid channel.

Source files
------------

// File: rtl/mux_pipe.sv
// N-to-1 channel multiplexer with a single-entry registered output stage and valid/ready flow.
// Define MUX_RR_EN to add a round-robin arbiter that is selected at run time by rr_mode.
module mux_pipe #(
  parameter int unsigned NUM_CH = 32,
  parameter int unsigned DATA_W = 2,
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     rr_mode,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err
);

  // One extra bit so that NUM_CH itself is representable for the range check.
  localparam logic [SEL_W:0] NumChX = (SEL_W + 1)'(NUM_CH);

  logic              can_load;
  logic              sel_oob;
  logic              fix_hit;
  logic              rr_active;
  logic              rr_hit;
  logic [SEL_W-1:0]  rr_idx;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;

  assign can_load = !out_valid || out_ready;
  assign sel_oob  = {1'b0, sel} >= NumChX;
  assign fix_hit  = !sel_oob && in_valid[sel];

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] last_grant;

  assign rr_active = rr_mode;

  // Upward search starting just past the previous winner, wrapping at NUM_CH.
  always_comb begin
    int unsigned idx;
    logic [SEL_W-1:0] idx_s;
    rr_hit = 1'b0;
    rr_idx = '0;
    idx    = 0;
    idx_s  = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_s = SEL_W'(idx);
      if (!rr_hit && in_valid[idx_s]) begin
        rr_hit = 1'b1;
        rr_idx = idx_s;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= SEL_W'(NUM_CH - 1);
    end else if (grant_vld) begin
      last_grant <= grant_idx;
    end
  end
`else
  logic unused_rr_mode;

  assign unused_rr_mode = rr_mode;
  assign rr_active      = 1'b0;
  assign rr_hit         = 1'b0;
  assign rr_idx         = '0;
`endif

  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = sel;
    grant_data = '0;
    in_ready   = '0;
    if (rr_active) begin
      grant_vld = rr_hit;
      grant_idx = rr_idx;
    end else begin
      grant_vld = fix_hit;
      grant_idx = sel;
    end
    // No transfer may complete while reset is held.
    grant_vld = grant_vld && can_load && !rst;
    if (grant_vld) in_ready[grant_idx] = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= !rr_active && sel_oob;
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
